// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer.
// Contents:
//   pcs_state_e      : BOOT / RUN / HALT state encodings (2 bits)
//   PCS_RESET_PC_DEF : default PC value loaded on reset
//   PCS_COUNT_WIDTH  : width of the optional taken-branch counter
//   pcs_flush        : wrong-path squash decision for the current cycle
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PCS_BOOT = 2'b00,
    PCS_RUN  = 2'b01,
    PCS_HALT = 2'b10
  } pcs_state_e;

  localparam int unsigned PCS_PC_WIDTH_DEF = 16;
  localparam logic [15:0] PCS_RESET_PC_DEF = 16'h0000;
  localparam int unsigned PCS_COUNT_WIDTH  = 16;

  // Both a taken redirect and a halt kill the two younger instructions in
  // IF and ID; nothing is squashed outside RUN or while reset is applied.
  function automatic logic pcs_flush(input logic       rst,
                                     input pcs_state_e state,
                                     input logic       pc_src,
                                     input logic       halt_req);
    return (!rst) && (state == PCS_RUN) && (pc_src || halt_req);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the branch-resolution inputs and the fetch-side outputs of the
// PC sequencer.
//   master : upstream/downstream environment (drives PCSrc, branchTarget,
//            stall, haltReq; observes the PC outputs)
//   slave  : the pc_sequencer itself
// Optional macro BRANCH_COUNT_EN adds the branchCount signal.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH = 16
);
  import pc_sequencer_pkg::*;

  logic                PCSrc;
  logic [PC_WIDTH-1:0] branchTarget;
  logic                stall;
  logic                haltReq;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcPlus1;
  logic                fetchValid;
  logic                flushIF;
  logic                flushID;
  logic                halted;
`ifdef BRANCH_COUNT_EN
  logic [PCS_COUNT_WIDTH-1:0] branchCount;

  modport master (
    output PCSrc, branchTarget, stall, haltReq,
    input  pc, pcPlus1, fetchValid, flushIF, flushID, halted, branchCount
  );

  modport slave (
    input  PCSrc, branchTarget, stall, haltReq,
    output pc, pcPlus1, fetchValid, flushIF, flushID, halted, branchCount
  );
`else
  modport master (
    output PCSrc, branchTarget, stall, haltReq,
    input  pc, pcPlus1, fetchValid, flushIF, flushID, halted
  );

  modport slave (
    input  PCSrc, branchTarget, stall, haltReq,
    output pc, pcPlus1, fetchValid, flushIF, flushID, halted
  );
`endif
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// pc_sequencer_sat_counter (sat_counter)
// Saturating up-counter used for the taken-branch statistic.
// Ports:
//   clk      : clock
//   clear_i  : synchronous clear (highest priority)
//   inc_i    : increment request; ignored once the counter is all ones
//   count_o  : current count (registered)
module pc_sequencer_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, then saturating increment, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter stage fed by branch resolution in EX. Selects the next
// fetch address (redirect > halt > stall > increment), squashes the two
// wrong-path instructions on a redirect or halt, and sequences the one-cycle
// boot after reset and the terminal HALT state.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if.slave
//          in : PCSrc, branchTarget, stall, haltReq
//          out: pc (reg), pcPlus1 (comb), fetchValid (reg), flushIF/flushID
//               (comb), halted (reg), branchCount (reg, BRANCH_COUNT_EN only)
// Optional macro BRANCH_COUNT_EN enables the saturating taken-branch counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = PCS_PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(PCS_RESET_PC_DEF)
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  pcs_state_e          state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                fetch_valid_q;
  logic                halted_q;
  logic [PC_WIDTH-1:0] pc_plus1_s;
  logic                flush_s;

  // Wraps naturally from all ones to zero.
  assign pc_plus1_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign flush_s    = pcs_flush(rst, state_q, bus.PCSrc, bus.haltReq);

  // State, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PCS_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        // Boot cycle absorbs the synchronous imem read latency.
        PCS_BOOT: begin
          state_q       <= PCS_RUN;
          fetch_valid_q <= 1'b1;
          halted_q      <= 1'b0;
        end
        PCS_RUN: begin
          if (bus.PCSrc) begin
            pc_q          <= bus.branchTarget;
            fetch_valid_q <= 1'b1;
          end else if (bus.haltReq) begin
            state_q       <= PCS_HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (bus.stall) begin
            pc_q          <= pc_q;
          end else begin
            pc_q          <= pc_plus1_s;
          end
        end
        // Terminal: only rst leaves HALT.
        PCS_HALT: begin
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b1;
        end
        default: begin
          state_q       <= PCS_BOOT;
          pc_q          <= RESET_PC;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pcPlus1    = pc_plus1_s;
  assign bus.fetchValid = fetch_valid_q;
  assign bus.flushIF    = flush_s;
  assign bus.flushID    = flush_s;
  assign bus.halted     = halted_q;

`ifdef BRANCH_COUNT_EN
  logic branch_inc_s;

  // Only taken redirects in RUN count; HALT and BOOT leave the count alone.
  assign branch_inc_s = (state_q == PCS_RUN) && bus.PCSrc;

  pc_sequencer_sat_counter #(
    .WIDTH (PCS_COUNT_WIDTH)
  ) u_branch_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (branch_inc_s),
    .count_o (bus.branchCount)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench: directed scenarios plus randomized stimulus compared
// every cycle against a behavioural model of the PC sequencer.
// Honours BRANCH_COUNT_EN when defined.
module tb_pc_sequencer;

  localparam int unsigned PW  = 16;
  localparam logic [15:0] RPC = 16'h0000;

  logic clk = 1'b0;
  logic rst;

  pc_sequencer_if #(.PC_WIDTH(PW)) bus ();

  pc_sequencer #(
    .PC_WIDTH (PW),
    .RESET_PC (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [15:0] m_pc;
  bit          m_boot;
  bit          m_halt;
  int unsigned m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cycle(input bit r, input bit br, input logic [15:0] tgt,
                       input bit st, input bit hr);
    logic [15:0] exp_p1;
    bit          exp_flush;
    @(negedge clk);
    rst              = r;
    bus.PCSrc        = br;
    bus.branchTarget = tgt;
    bus.stall        = st;
    bus.haltReq      = hr;
    #1;
    exp_p1    = m_pc + 16'd1;
    exp_flush = !r && !m_boot && !m_halt && (br || hr);
    check_val("pc",         32'(bus.pc),         32'(m_pc));
    check_val("pcPlus1",    32'(bus.pcPlus1),    32'(exp_p1));
    check_val("fetchValid", 32'(bus.fetchValid), 32'(!m_boot && !m_halt));
    check_val("halted",     32'(bus.halted),     32'(m_halt));
    check_val("flushIF",    32'(bus.flushIF),    32'(exp_flush));
    check_val("flushID",    32'(bus.flushID),    32'(exp_flush));
`ifdef BRANCH_COUNT_EN
    check_val("branchCount", 32'(bus.branchCount), m_cnt);
`endif
    @(posedge clk);
    if (r) begin
      m_pc = RPC; m_boot = 1'b1; m_halt = 1'b0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (br) begin
      m_pc = tgt;
      if (m_cnt < 32'd65535) m_cnt = m_cnt + 1;
    end else if (hr) begin
      m_halt = 1'b1;
    end else if (!st) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.PCSrc        = 1'b0;
    bus.branchTarget = 16'h0000;
    bus.stall        = 1'b0;
    bus.haltReq      = 1'b0;
    repeat (2) @(posedge clk);
    m_pc = RPC; m_boot = 1'b1; m_halt = 1'b0; m_cnt = 0;

    // Reset held with busy inputs: no flush, reset values visible.
    cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);

    // Reset release: BOOT at RESET_PC, then RUN at RESET_PC, then +1.
    idle();
    idle();
    idle();
    check_val("boot_seq_pc", 32'(bus.pc), 32'h1);

    // Redirect beats stall.
    cycle(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
    idle();

    // Three stall cycles at 0x0010, then increment.
    cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle();

    // Wrap-around from 0xFFFF.
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    idle();
    idle();

    // Reset mid-run overrides redirect/stall/halt.
    cycle(1'b1, 1'b1, 16'h0777, 1'b1, 1'b1);
    idle();
    idle();

    // Halt at 0x0020; later redirect ignored; reset recovers.
    cycle(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0099, 1'b1, 1'b1);
    idle();
    check_val("halt_pc", 32'(bus.pc), 32'h20);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    idle();

`ifdef BRANCH_COUNT_EN
    // Five taken branches, then saturation after many redirects.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'(i * 3), 1'b0, 1'b0);
    @(negedge clk); #1;
    check_val("branchCount_5", 32'(bus.branchCount), 32'd5);
    for (int i = 0; i < 65540; i++)
      cycle(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
    @(negedge clk); #1;
    check_val("branchCount_sat", 32'(bus.branchCount), 32'hFFFF);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 24) == 0),
            ($urandom_range(0, 5) == 0),
            16'($urandom),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 40) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage that sits directly downstream of the branch-resolution logic: it consumes `PCSrc` and the branch target from EX and produces the fetch address for instruction memory. It owns PC update priority (redirect, halt, stall, increment), squashes the wrong-path instructions in IF and ID on a taken branch, and sequences the post-reset boot cycle and processor halt.

## Interface
- `PC_WIDTH`, 16, width of PC and branch target; word-addressed.
- `RESET_PC`, 0, PC value loaded on reset.
- `clk  in  1  single clock; all state updates on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `PCSrc  in  1  taken-branch redirect from branch resolution (EX stage)`
- `branchTarget  in  PC_WIDTH  redirect address, valid when PCSrc=1`
- `stall  in  1  hazard-unit request to hold PC`
- `haltReq  in  1  HALT instruction reached EX`
- `pc  out  PC_WIDTH  current fetch address (registered)`
- `pcPlus1  out  PC_WIDTH  pc+1 mod 2^PC_WIDTH (combinational)`
- `fetchValid  out  1  instruction memory output is a real instruction`
- `flushIF  out  1  squash IF/ID register at next edge`
- `flushID  out  1  squash ID/EX register at next edge`
- `halted  out  1  processor stopped`
- `branchCount  out  16  taken-branch counter (only with BRANCH_COUNT_EN)`

## Operation
- FSM states: BOOT, RUN, HALT. Encoding is 2 bits.
- Reset values: state=BOOT, pc=RESET_PC, fetchValid=0, halted=0, branchCount=0; flushIF/flushID forced 0 while rst=1.
- BOOT: pc held, fetchValid=0, no flush; unconditionally -> RUN next cycle (covers synchronous instruction-memory read latency).
- RUN, next-PC priority (highest first):
  - PCSrc=1: pc<=branchTarget; flushIF=flushID=1 this cycle; stall and haltReq ignored.
  - haltReq=1: pc held; -> HALT; flushIF=flushID=1.
  - stall=1: pc held; no flush.
  - otherwise pc<=pcPlus1.
- fetchValid=1 in RUN, 0 in BOOT and HALT.
- HALT: pc frozen, halted=1, all inputs except rst ignored; exit only via rst.
- flushIF/flushID are combinational from state and inputs; asserted only in RUN.
- Wrap-around: pc=2^PC_WIDTH-1 increments to 0; no flag.
- branchTarget is used unmodified; no alignment checks.

## Timing
- Redirect latency: PCSrc high in cycle n -> pc=branchTarget in cycle n+1; the two wrong-path instructions squashed at the edge ending cycle n. Penalty: 2 bubbles.
- Stall: pc holds for exactly the number of cycles stall=1.
- Halt: haltReq in cycle n -> halted=1 and fetchValid=0 from cycle n+1.
- Reset mid-operation: rst sampled at edge overrides everything; next cycle is BOOT regardless of PCSrc/stall/haltReq.
- Release of reset: first cycle BOOT (pc=RESET_PC, fetchValid=0), second cycle RUN at RESET_PC with fetchValid=1.

## Configuration
- `BRANCH_COUNT_EN` defined: `branchCount` port present; 16-bit counter increments on every cycle with state=RUN and PCSrc=1; saturates at 16'hFFFF; cleared by rst; held in HALT.
- Undefined: no counter, no `branchCount` port; all other behaviour identical.

## Structure
- Shared defines file: state encodings `PCS_BOOT`, `PCS_RUN`, `PCS_HALT`, and default `RESET_PC`.
- Optional sub-module `sat_counter` (width parameter, inc, clear, saturating) instanced only under `BRANCH_COUNT_EN`; everything else in one module.

## Test plan
- Reset release with RESET_PC=0 -> cycle 1: pc=0, fetchValid=0; cycle 2: pc=0, fetchValid=1; cycle 3: pc=1.
- PCSrc=1, branchTarget=16'h0040 while stall=1 -> flushIF=flushID=1 same cycle; next cycle pc=16'h0040 (redirect beats stall).
- stall=1 for 3 cycles at pc=16'h0010 -> pc stays 16'h0010 for 3 cycles, no flush, then 16'h0011.
- pc=16'hFFFF, no stall -> next pc=16'h0000.
- haltReq=1 at pc=16'h0020 -> next cycle halted=1, fetchValid=0, pc=16'h0020; later PCSrc=1 ignored; rst -> BOOT, pc=RESET_PC, halted=0.
- With `BRANCH_COUNT_EN`: 5 taken branches -> branchCount=5; counter preset near max by 65535+ redirects stays at 16'hFFFF.
